// File: rtl/cfg_frame_rx_pkg.sv
// cfg_frame_rx_pkg
//   Shared definitions for the configuration-frame UART receiver and the
//   control FSM that consumes its frames:
//     - default baud divider
//     - bit-level receiver state encoding
//     - cfg_data field positions (cmd, eep address, data)
package cfg_frame_rx_pkg;

  localparam int BAUD_DIV_DEF = 2604;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // cfg_data field layout
  localparam int CFG_CMD_HI = 19;
  localparam int CFG_CMD_LO = 18;
  localparam int CFG_EEP_HI = 17;
  localparam int CFG_EEP_LO = 16;
  localparam int CFG_DAT_HI = 13;
  localparam int CFG_DAT_LO = 0;

  function automatic logic [1:0] cfg_cmd(input logic [23:0] f);
    return f[CFG_CMD_HI:CFG_CMD_LO];
  endfunction

  function automatic logic [1:0] cfg_eep(input logic [23:0] f);
    return f[CFG_EEP_HI:CFG_EEP_LO];
  endfunction

  function automatic logic [13:0] cfg_dat(input logic [23:0] f);
    return f[CFG_DAT_HI:CFG_DAT_LO];
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART byte receiver, LSB first.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     i_rx       : raw serial line (idle high)
//     o_byte     : last shifted byte (valid while o_rdy is high)
//     o_rdy      : one-cycle strobe, byte accepted (stop bit sampled 1)
//     o_err      : one-cycle strobe, framing error (stop bit sampled 0)
//   Strobes are combinational in the stop-bit sample cycle so the frame
//   assembler can register them with a single cycle of latency.
module uart_rx_byte
  import cfg_frame_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_rdy,
  output logic       o_err
);

  localparam int            CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  logic [1:0]    r_sync;
  logic          r_rx_d;
  logic          w_rx;
  rx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_rdy, w_err;

  assign w_rx = r_sync[1];

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_rx_d <= w_rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_rdy       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rx_d && !w_rx) w_state_nxt = RX_START;
      end
      RX_START: begin
        // Mid start bit: a line already back high was a glitch.
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == BAUD_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == BAUD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (w_rx) w_rdy = 1'b1;
          else      w_err = 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_byte = r_shift;
  assign o_rdy  = w_rdy;
  assign o_err  = w_err;

endmodule

// File: rtl/cfg_frame_rx.sv
// cfg_frame_rx
//   Receives 3-byte configuration frames over an 8N1 UART and presents the
//   assembled 24-bit word to the control FSM.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     RX         : serial line (idle high)
//     clr_rdy    : strobe from control FSM, consumes the current frame
//     cfg_data   : last complete frame, byte 0 in [23:16]
//     frm_rdy    : frame available and not yet consumed
//     frm_err    : one-cycle pulse on framing error
//     overrun    : one-cycle pulse when an unconsumed frame is overwritten
module cfg_frame_rx
  import cfg_frame_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_rdy,
  output logic [23:0] cfg_data,
  output logic        frm_rdy,
  output logic        frm_err,
  output logic        overrun
);

  logic [7:0]  w_byte;
  logic        w_byte_rdy, w_byte_err, w_frame_done;
  logic [1:0]  r_idx;
  logic [15:0] r_asm;   // bytes 0 and 1; byte 2 goes straight to cfg_data
  logic [23:0] r_cfg;
  logic        r_rdy, r_err, r_ovr;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV),
    .HALF_DIV (HALF_DIV)
  ) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (RX),
    .o_byte (w_byte),
    .o_rdy  (w_byte_rdy),
    .o_err  (w_byte_err)
  );

  assign w_frame_done = w_byte_rdy && (r_idx == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_asm <= '0;
      r_cfg <= '0;
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_err <= w_byte_err;
      r_ovr <= 1'b0;
      // Byte index survives idle gaps; only an error or a full frame resets it.
      if (w_byte_err) begin
        r_idx <= '0;
      end else if (w_byte_rdy) begin
        case (r_idx)
          2'd0: begin
            r_asm[15:8] <= w_byte;
            r_idx       <= 2'd1;
          end
          2'd1: begin
            r_asm[7:0]  <= w_byte;
            r_idx       <= 2'd2;
          end
          default: begin
            r_cfg <= {r_asm, w_byte};
            r_idx <= 2'd0;
            r_ovr <= r_rdy && !clr_rdy;
          end
        endcase
      end
      // Completion outranks a same-cycle clear.
      if (w_frame_done)  r_rdy <= 1'b1;
      else if (clr_rdy)  r_rdy <= 1'b0;
    end
  end

  assign cfg_data = r_cfg;
  assign frm_rdy  = r_rdy;
  assign frm_err  = r_err;
  assign overrun  = r_ovr;

endmodule
